// File: rtl/oven_pkg.sv
// Shared definitions for the oven cook timer: controller states and the BCD
// digit constants used by the time register.
package oven_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [3:0] ZERO = 4'd0;
  localparam logic [3:0] NINE = 4'd9;
  localparam logic [3:0] FIVE = 4'd5;

  // One BCD digit minus one, wrapping to the given top value on borrow.
  function automatic logic [3:0] bcd_dec(input logic [3:0] d, input logic [3:0] wrap);
    return (d == ZERO) ? wrap : d - 4'd1;
  endfunction

endpackage

// File: rtl/bcd_time_dec.sv
// Four-digit MM:SS BCD register: keypad shift-in, clear, and a borrow-correct
// one-second decrement.
module bcd_time_dec
  import oven_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       clr,
  input  logic       shift_en,
  input  logic       dec_en,
  input  logic [3:0] digit,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       is_zero,
  output logic       is_one
);

  assign is_zero = (min_tens == ZERO) && (min_ones == ZERO) &&
                   (sec_tens == ZERO) && (sec_ones == ZERO);
  assign is_one  = (min_tens == ZERO) && (min_ones == ZERO) &&
                   (sec_tens == ZERO) && (sec_ones == 4'd1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      min_tens <= ZERO;
      min_ones <= ZERO;
      sec_tens <= ZERO;
      sec_ones <= ZERO;
    end else if (clr) begin
      min_tens <= ZERO;
      min_ones <= ZERO;
      sec_tens <= ZERO;
      sec_ones <= ZERO;
    end else if (shift_en) begin
      min_tens <= min_ones;
      min_ones <= sec_tens;
      sec_tens <= sec_ones;
      sec_ones <= digit;
    end else if (dec_en && !is_zero) begin
      // Borrow ripples only through digits that are currently zero.
      sec_ones <= bcd_dec(sec_ones, NINE);
      if (sec_ones == ZERO) begin
        sec_tens <= bcd_dec(sec_tens, FIVE);
        if (sec_tens == ZERO) begin
          min_ones <= bcd_dec(min_ones, NINE);
          if (min_ones == ZERO) begin
            min_tens <= bcd_dec(min_tens, NINE);
          end
        end
      end
    end
  end

endmodule

// File: rtl/cook_timer.sv
// Microwave cook timer: keypad time entry, start/stop/clear control, door
// interlock and a one-second countdown derived from a clk prescaler.
module cook_timer
  import oven_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       door_closed,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       timer_done
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  state_t        state;
  logic [PW-1:0] presc;
  logic          tick;
  logic          clr_time;
  logic          shift_en;
  logic          dec_en;
  logic          time_zero;
  logic          time_one;

  bcd_time_dec u_time (
    .clk      (clk),
    .resetn   (resetn),
    .clr      (clr_time),
    .shift_en (shift_en),
    .dec_en   (dec_en),
    .digit    (digit),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .is_zero  (time_zero),
    .is_one   (time_one)
  );

  // Time-register strobes follow the same event priority as the FSM below.
  always_comb begin
    tick     = (presc == LAST);
    clr_time = 1'b0;
    shift_en = 1'b0;
    dec_en   = 1'b0;
    if (clear) begin
      clr_time = 1'b1;
    end else if (stop) begin
      clr_time = (state == ST_PAUSED);
    end else if (!door_closed) begin
      clr_time = 1'b0;
    end else if (state == ST_RUNNING) begin
      dec_en = tick;
    end else if (state == ST_IDLE && !start && digit_valid) begin
      shift_en = (digit <= NINE) && (sec_ones <= FIVE);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      presc      <= '0;
      running    <= 1'b0;
      timer_done <= 1'b0;
    end else if (clear) begin
      state      <= ST_IDLE;
      presc      <= '0;
      running    <= 1'b0;
      timer_done <= 1'b0;
    end else if (stop) begin
      case (state)
        ST_RUNNING: begin
          state   <= ST_PAUSED;
          running <= 1'b0;
        end
        ST_PAUSED: begin
          state <= ST_IDLE;
          presc <= '0;
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          timer_done <= 1'b0;
        end
        default: ;
      endcase
    end else if (!door_closed) begin
      case (state)
        ST_RUNNING: begin
          state   <= ST_PAUSED;
          running <= 1'b0;
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          timer_done <= 1'b0;
        end
        default: ;
      endcase
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !time_zero) begin
            state   <= ST_RUNNING;
            presc   <= '0;
            running <= 1'b1;
          end
        end
        ST_PAUSED: begin
          if (start) begin
            state   <= ST_RUNNING;
            running <= 1'b1;
          end
        end
        ST_RUNNING: begin
          if (tick) begin
            presc <= '0;
            if (time_one) begin
              state      <= ST_DONE;
              running    <= 1'b0;
              timer_done <= 1'b1;
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
